sequential_arithmetic_right_shifter: RTL and testbench



---
 rtl/sequential_arithmetic_right_shifter_if.sv | 17 +
 rtl/sequential_arithmetic_right_shifter.sv | 66 ++++++
 tb/tb_sequential_arithmetic_right_shifter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sequential_arithmetic_right_shifter_if.sv
// Start/busy/done handshake bundle for the sequential arithmetic right shifter.
// The controller side drives the request; the shifter returns the result and status.
interface sequential_arithmetic_right_shifter_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] shift;
  logic [N-1:0] y;
  logic         busy;
  logic         done;

  modport master (output start, output a, output shift,
                  input  y,     input  busy, input  done);
  modport slave  (input  start, input  a,    input  shift,
                  output y,     output busy, output done);
endinterface

// File: rtl/sequential_arithmetic_right_shifter.sv
// Multi-cycle arithmetic right shifter: one sign-filling shift per clock,
// with the amount clamped to N so large shifts saturate to all sign bits.
//
//   state   | meaning
//   S_IDLE  | waiting for start; latches operand and clamped amount
//   S_SHIFT | one sign-filling shift per cycle until count reaches 0
//   S_DONE  | result published, done high for this single cycle
module sequential_arithmetic_right_shifter #(
  parameter int N = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  sequential_arithmetic_right_shifter_if.slave bus
);

  localparam int           CW    = $clog2(N + 1);
  localparam logic [N-1:0] N_OP  = N'(N);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_work;
  logic [N-1:0]  r_y;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_y     <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work  <= bus.a;
            // Amounts of N or more all end in pure sign fill, so N shifts suffice.
            r_count <= (bus.shift >= N_OP) ? N_CNT : CW'(bus.shift);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_count != '0) begin
            r_work  <= {r_work[N-1], r_work[N-1:1]};
            r_count <= r_count - CW'(1);
          end else begin
            r_y     <= r_work;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.y    = r_y;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);

endmodule

// File: tb/tb_sequential_arithmetic_right_shifter.sv
// Scoreboard bench for the sequential arithmetic right shifter at N=4 and N=8:
// the driver queues expected results and done cycles, per-DUT monitors pop them on done.
module tb_sequential_arithmetic_right_shifter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sequential_arithmetic_right_shifter_if #(.N(4)) b4 ();
  sequential_arithmetic_right_shifter_if #(.N(8)) b8 ();

  sequential_arithmetic_right_shifter #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  sequential_arithmetic_right_shifter #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    logic [7:0] y;
    int         due;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 0) ? 4 : 8;
  endfunction

  function automatic logic [7:0] mask_of(input int sel);
    return (sel == 0) ? 8'h0f : 8'hff;
  endfunction

  // Reference: signed value of a, arithmetic-shifted by min(shift, n), truncated to n bits.
  function automatic logic [7:0] ref_asr(input int n, input logic [7:0] a, input logic [7:0] sh);
    int         av;
    int         k;
    int         r;
    logic [7:0] m;
    m  = 8'((1 << n) - 1);
    av = int'(a & m);
    if (av >= (1 << (n - 1))) av = av - (1 << n);
    k = (int'(sh) > n) ? n : int'(sh);
    r = av >>> k;
    return 8'(r) & m;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] sh);
    if (sel == 0) begin
      b4.start = st;
      b4.a     = a[3:0];
      b4.shift = sh[3:0];
    end else begin
      b8.start = st;
      b8.a     = a;
      b8.shift = sh;
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? b4.busy : b8.busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? b4.done : b8.done;
  endfunction

  function automatic logic [7:0] y_of(input int sel);
    return (sel == 0) ? {4'h0, b4.y} : b8.y;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? q4.size() : q8.size();
  endfunction

  task automatic push_exp(input int sel, input logic [7:0] y, input int due);
    exp_t e;
    e.y   = y;
    e.due = due;
    if (sel == 0) q4.push_back(e);
    else          q8.push_back(e);
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic on_done(input int sel, input logic [7:0] y);
    exp_t e;
    if (qsize(sel) == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_done dut%0d: got done=1 y=0x%0h expected no done (cycle %0d)", sel, y, cyc);
      return;
    end
    if (sel == 0) e = q4.pop_front();
    else          e = q8.pop_front();
    chk($sformatf("result_y dut%0d", sel), {24'h0, y}, {24'h0, e.y});
    if (e.due >= 0) chk($sformatf("done_cycle dut%0d", sel), cyc, e.due);
  endtask

  always @(negedge clk) if (rst_n && b4.done === 1'b1) on_done(0, {4'h0, b4.y});
  always @(negedge clk) if (rst_n && b8.done === 1'b1) on_done(1, b8.y);

  task automatic issue(input int sel, input logic [7:0] a_in, input logic [7:0] sh_in,
                       input bit hold, output int e0);
    int         n;
    int         k;
    logic [7:0] a;
    logic [7:0] sh;
    n  = width_of(sel);
    a  = a_in & mask_of(sel);
    sh = sh_in & mask_of(sel);
    drive(sel, 1'b1, a, sh);
    step;
    e0 = cyc;
    k  = (int'(sh) > n) ? n : int'(sh);
    push_exp(sel, ref_asr(n, a, sh), e0 + k + 1);
    chk($sformatf("busy_after_start dut%0d", sel), {31'h0, busy_of(sel)}, 32'd1);
    if (!hold) drive(sel, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  task automatic wait_done(input int sel, input string nm);
    int t;
    t = 0;
    while (qsize(sel) != 0 && t < 60) begin
      step;
      t++;
    end
    if (qsize(sel) != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, t);
      if (sel == 0) q4.delete();
      else          q8.delete();
    end
    step;
    chk({nm, "_done_low"}, {31'h0, done_of(sel)}, 32'd0);
    chk({nm, "_busy_low"}, {31'h0, busy_of(sel)}, 32'd0);
  endtask

  initial begin
    int         e0;
    int         t;
    bit         hold;
    logic [7:0] ra;
    logic [7:0] rs;

    drive(0, 1'b0, 8'h0, 8'h0);
    drive(1, 1'b0, 8'h0, 8'h0);
    repeat (3) step;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_y dut%0d", s),    {24'h0, y_of(s)},     32'd0);
      chk($sformatf("reset_busy dut%0d", s), {31'h0, busy_of(s)},  32'd0);
      chk($sformatf("reset_done dut%0d", s), {31'h0, done_of(s)},  32'd0);
    end
    rst_n = 1'b1;
    step;

    issue(0, 8'b1000, 8'd1, 1'b0, e0);
    wait_done(0, "t1");

    issue(0, 8'b0110, 8'd2, 1'b0, e0);
    step;
    chk("y_hold_during_shift", {24'h0, y_of(0)}, 32'b1100);
    wait_done(0, "t2");

    issue(0, 8'b1011, 8'd0, 1'b0, e0);
    wait_done(0, "t3");

    issue(0, 8'b0111, 8'd9, 1'b0, e0);
    wait_done(0, "clamp9");

    issue(0, 8'b1001, 8'b1111, 1'b0, e0);
    wait_done(0, "clamp15");

    // Start held high across the whole operation; operand changes after sampling.
    issue(0, 8'b1000, 8'd3, 1'b1, e0);
    drive(0, 1'b1, 8'b0101, 8'd3);
    t = 0;
    while (q4.size() != 0 && t < 20) begin
      step;
      t++;
    end
    chk("held_first_done_seen", q4.size(), 32'd0);
    q4.delete();
    drive(0, 1'b1, 8'b0100, 8'd1);
    push_exp(0, 8'b0010, -1);
    step;
    step;
    drive(0, 1'b0, 8'h0, 8'h0);
    wait_done(0, "held2");

    issue(0, 8'b1000, 8'd3, 1'b0, e0);
    step;
    step;
    rst_n = 1'b0;
    #1;
    chk("async_reset_y",    {24'h0, y_of(0)},    32'd0);
    chk("async_reset_busy", {31'h0, busy_of(0)}, 32'd0);
    chk("async_reset_done", {31'h0, done_of(0)}, 32'd0);
    q4.delete();
    step;
    step;
    rst_n = 1'b1;
    repeat (6) step;
    chk("post_reset_idle_busy", {31'h0, busy_of(0)}, 32'd0);
    issue(0, 8'b0100, 8'd1, 1'b0, e0);
    wait_done(0, "after_reset");

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 500; i++) begin
        repeat ($urandom_range(0, 3)) step;
        ra   = 8'($urandom);
        rs   = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                           : 8'($urandom_range(0, width_of(s) + 1));
        hold = ($urandom_range(0, 3) == 0);
        issue(s, ra, rs, hold, e0);
        if (hold) begin
          step;
          drive(s, 1'b0, 8'($urandom), 8'($urandom));
        end
        wait_done(s, $sformatf("rand%0d", s));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
